// File: rtl/noc_params_pkg.sv
// Shared NoC types and constants: flit format, flit labels, per-VC packet state.
package noc_params;

  localparam int VC_NUM   = 2;
  localparam int VC_DEPTH = 4;
  localparam int PL_W     = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t       flit_label;
    logic [PL_W-1:0]   bt_pl;
  } flit_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } vc_pkt_state_t;

  // Next packet state on an accepted write. HEAD in ACTIVE stays ACTIVE.
  function automatic vc_pkt_state_t pkt_next(vc_pkt_state_t s, flit_label_t l);
    case (l)
      HEAD:     pkt_next = ACTIVE;
      TAIL:     pkt_next = IDLE;
      HEADTAIL: pkt_next = IDLE;
      default:  pkt_next = s;
    endcase
  endfunction

  // Flit label that is illegal in the current packet state.
  function automatic logic pkt_violation(vc_pkt_state_t s, flit_label_t l);
    case (l)
      HEAD:    pkt_violation = (s == ACTIVE);
      BODY:    pkt_violation = (s == IDLE);
      TAIL:    pkt_violation = (s == IDLE);
      default: pkt_violation = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vc_buffer_bank_slice.sv
// Single-VC flit store: circular array, pointers, occupancy and packet FSM.
// The parent only asserts wr_en_i/rd_en_i for accepted operations.
// Optional VC_BUF_ERR_EN adds proto_err_o (protocol violation on this write).
module vc_fifo_slice
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = VC_DEPTH,
  localparam int PTR_W = $clog2(BUFFER_SIZE),
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  input  flit_t            data_i,
  output flit_t            head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             pkt_active_o
`ifdef VC_BUF_ERR_EN
  ,
  output logic             proto_err_o
`endif
);

  flit_t             mem [BUFFER_SIZE];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  vc_pkt_state_t     state_q;

  // Occupancy next state: simultaneous read+write cancels out.
  always_comb begin
    count_d = count_q;
    case ({wr_en_i, rd_en_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally modulo BUFFER_SIZE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage is not reset; only written on accepted writes.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_ptr_q] <= data_i;
  end

  // Packet tracker, advanced only by accepted writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         state_q <= IDLE;
    else if (wr_en_i) state_q <= pkt_next(state_q, data_i.flit_label);
  end

  assign head_o       = mem[rd_ptr_q];
  assign count_o      = count_q;
  assign full_o       = (count_q == CNT_W'(BUFFER_SIZE));
  assign empty_o      = (count_q == '0);
  assign pkt_active_o = (state_q == ACTIVE);

`ifdef VC_BUF_ERR_EN
  assign proto_err_o = wr_en_i && pkt_violation(state_q, data_i.flit_label);
`endif

endmodule

// File: rtl/vc_buffer_bank.sv
// Multi-VC input buffer bank: shared write/read ports demuxed onto VC_NUM
// vc_fifo_slice instances, registered read data and one-cycle credit return.
// Optional feature macro VC_BUF_ERR_EN adds sticky err_o.
module vc_buffer_bank
  import noc_params::*;
#(
  parameter int VC_NUM      = noc_params::VC_NUM,
  parameter int BUFFER_SIZE = VC_DEPTH,
  localparam int VC_W  = $clog2(VC_NUM),
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  flit_t                            data_i,
  input  logic                             write_i,
  input  logic [VC_W-1:0]                  write_vc_i,
  input  logic                             read_i,
  input  logic [VC_W-1:0]                  read_vc_i,
  output flit_t                            data_o,
  output flit_t [VC_NUM-1:0]               peek_o,
  output logic [VC_NUM-1:0]                is_full_o,
  output logic [VC_NUM-1:0]                is_empty_o,
  output logic [VC_NUM-1:0][CNT_W-1:0]     count_o,
  output logic [VC_NUM-1:0]                pkt_active_o,
  output logic                             credit_valid_o,
  output logic [VC_W-1:0]                  credit_vc_o
`ifdef VC_BUF_ERR_EN
  ,
  output logic                             err_o
`endif
);

  logic              rd_acc, wr_acc;
  logic [VC_NUM-1:0] wr_sel, rd_sel;
  flit_t             data_q;
  logic              credit_valid_q;
  logic [VC_W-1:0]   credit_vc_q;

  // Read needs data present; write needs room, or a same-VC read freeing a slot.
  assign rd_acc = read_i && !is_empty_o[read_vc_i];
  assign wr_acc = write_i &&
                  (!is_full_o[write_vc_i] || (rd_acc && (read_vc_i == write_vc_i)));

`ifdef VC_BUF_ERR_EN
  logic [VC_NUM-1:0] proto_err_w;
  logic              err_q;
`endif

  for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
    assign wr_sel[g] = wr_acc && (write_vc_i == VC_W'(g));
    assign rd_sel[g] = rd_acc && (read_vc_i == VC_W'(g));

    vc_fifo_slice #(.BUFFER_SIZE(BUFFER_SIZE)) u_slice (
      .clk          (clk),
      .rst          (rst),
      .wr_en_i      (wr_sel[g]),
      .rd_en_i      (rd_sel[g]),
      .data_i       (data_i),
      .head_o       (peek_o[g]),
      .count_o      (count_o[g]),
      .full_o       (is_full_o[g]),
      .empty_o      (is_empty_o[g]),
      .pkt_active_o (pkt_active_o[g])
`ifdef VC_BUF_ERR_EN
      ,
      .proto_err_o  (proto_err_w[g])
`endif
    );
  end

  // Registered dequeue data and credit pulse; credit VC holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q         <= '0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
    end else begin
      credit_valid_q <= rd_acc;
      if (rd_acc) begin
        data_q      <= peek_o[read_vc_i];
        credit_vc_q <= read_vc_i;
      end
    end
  end

  assign data_o         = data_q;
  assign credit_valid_o = credit_valid_q;
  assign credit_vc_o    = credit_vc_q;

`ifdef VC_BUF_ERR_EN
  // Sticky error: full-drop, empty read, or packet protocol violation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else if ((write_i && !wr_acc) || (read_i && !rd_acc) || (|proto_err_w))
      err_q <= 1'b1;
  end
  assign err_o = err_q;
`endif

endmodule

// File: doc/vc_buffer_bank.md
Name: vc_buffer_bank

Overview:
Multi-virtual-channel input buffer bank for one router input port; generalises the single circular_buffer to VC_NUM independent flit FIFOs behind one shared write port and one shared read port. Each VC has a packet-state tracker (HEAD opens a packet, TAIL closes it). Each VC returns a one-cycle credit pulse to the upstream router per dequeued flit. Sits between the link receiver and the VC/switch allocators.

Parameters:
VC_NUM, 2, number of virtual channels (power of two, >=2)
BUFFER_SIZE, VC_DEPTH, flit slots per VC (power of two, >=2)
VC_W, $clog2(VC_NUM), derived, VC index width (localparam)
CNT_W, $clog2(BUFFER_SIZE+1), derived, occupancy width (localparam)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
data_i  in  flit_t  incoming flit
write_i  in  1  write strobe
write_vc_i  in  VC_W  target VC of write
read_i  in  1  read strobe from switch traversal
read_vc_i  in  VC_W  VC to dequeue
data_o  out  flit_t  registered dequeued flit
peek_o  out  flit_t[VC_NUM]  combinational head flit of each VC
is_full_o  out  VC_NUM  per-VC full
is_empty_o  out  VC_NUM  per-VC empty
count_o  out  CNT_W[VC_NUM]  per-VC occupancy
pkt_active_o  out  VC_NUM  VC is inside an open packet
credit_valid_o  out  1  credit pulse to upstream
credit_vc_o  out  VC_W  VC being credited

Behaviour:
- Reset (rst=0, asynchronous): all read/write pointers and counts 0, is_empty_o all 1, is_full_o all 0, data_o='0, credit_valid_o=0, credit_vc_o=0, pkt_active_o all 0. Storage array is not reset; peek_o of an empty VC is don't-care.
- Pointers are PTR_W=$clog2(BUFFER_SIZE) bits and wrap naturally modulo BUFFER_SIZE. Full/empty are derived from count, not pointer compare.
- Write is accepted when write_i=1 and either the target VC is not full, or a read of the same VC is accepted in the same cycle. An accepted write stores data_i at wr_ptr and increments wr_ptr. A rejected write is dropped, with no state change.
- Read is accepted when read_i=1 and read_vc_i is not empty. data_o<=slot[rd_ptr] at the edge and rd_ptr increments. Latency is one cycle from strobe to data_o. data_o holds its value when no read is accepted. A read of an empty VC is ignored and data_o is held.
- Same-VC simultaneous read+write leaves count unchanged. This is legal on a full VC and on a non-empty VC. On an empty VC the write is accepted and the read is ignored; there is no fall-through.
- Different-VC read+write updates each VC independently.
- Credit: credit_valid_o=1 for exactly one cycle, in the cycle after each accepted read, with credit_vc_o equal to that read's VC. Otherwise credit_valid_o=0 and credit_vc_o holds its last value.
- Packet FSM per VC, states IDLE/ACTIVE, advanced only on accepted writes:
  - IDLE + HEAD -> ACTIVE
  - ACTIVE + TAIL -> IDLE
  - HEADTAIL -> IDLE from either state
  - BODY keeps the state
  - pkt_active_o = (state==ACTIVE)
  - Protocol violations (BODY/TAIL in IDLE, HEAD in ACTIVE) still store the flit; the state follows the table above, with HEAD in ACTIVE staying ACTIVE.
- Reset mid-packet or mid-read returns to the reset values immediately; any credit in flight is lost.

Optional Feature:
Macro VC_BUF_ERR_EN.
- Defined: adds output err_o (1 bit), sticky until reset. It sets on any of:
  - write rejected because the VC is full
  - read of an empty VC
  - packet protocol violation
  err_o sets one cycle after the offending edge.
- Undefined: the port is absent, no error logic is built, and all other behaviour is identical.

Decomposition:
- flit_t, flit_label values (HEAD, BODY, TAIL, HEADTAIL) and VC_DEPTH stay in noc_params.
- Add to noc_params:
  - vc_pkt_state_t enum {IDLE, ACTIVE}
  - VC_NUM default constant
- One sub-module, vc_fifo_slice: a single-VC store with pointers, count and packet FSM, instantiated VC_NUM times via generate. The top holds write/read demux, the data_o register and the credit register.

Test Plan:
Bench config: VC_NUM=2, BUFFER_SIZE=4 throughout.
1. Write 4 flits (bt_pl 0x1..0x4) to VC0 -> is_full_o=2'b01, count_o[0]=4, VC1 empty; a 5th write to VC0 is dropped and count_o[0] stays 4.
2. From full VC0, read VC0 twice -> data_o=0x1 then 0x2, each one cycle after its strobe; credit_valid_o pulses twice with credit_vc_o=0; count_o[0]=2.
3. Wrap-around: write 0x5 and 0x6 to VC0, then read 4 times -> data_o=0x3,0x4,0x5,0x6, then is_empty_o[0]=1.
4. VC0 full, same-cycle read VC0 + write 0x7 to VC0 -> count stays 4, data_o=oldest flit, 0x7 is later read last.
5. Interleave: write HEAD to VC1, then BODY to VC0 with VC0 idle -> pkt_active_o=2'b10; with VC_BUF_ERR_EN defined, err_o=1 one cycle later. Then a TAIL to VC1 gives pkt_active_o=2'b00.
6. Assert rst=0 asynchronously mid-stream with VC0 holding 3 flits -> outputs go to reset values without waiting for a clock edge; after release, a first read of VC0 is ignored (empty).
